// File: rtl/pipe_hazard_sequencer_if.sv
// Hazard/control bundle between the pipeline datapath (master) and the
// hazard sequencer (slave).
interface pipe_hazard_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_hold_o;
    logic             err_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               branch_taken_i, dmem_req_i, dmem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               pipe_hold_o, err_o, state_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               branch_taken_i, dmem_req_i, dmem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               pipe_hold_o, err_o, state_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline hazard/sequencing controller: load-use bubbles, branch flushes, memory freeze,
// start-up and sticky memory timeout. Optional stall/flush counters under PERF_CNT_EN.
module pipe_hazard_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input logic                    clk_i,
    input logic                    rst_i,
    pipe_hazard_sequencer_if.slave hz
);
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StMemWait = 3'd2,
        StError   = 3'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;

    logic lu, mem_stall;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;

    always_comb begin
        lu = hz.idex_memread_i && (hz.idex_rt_i != 5'd0) &&
             ((hz.idex_rt_i == hz.ifid_rs_i) || (hz.idex_rt_i == hz.ifid_rt_i));
        mem_stall   = hz.dmem_req_i && !hz.dmem_ready_i;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        unique case (state_q)
            StIdle: begin
                idex_bubble = 1'b1;
                if (hz.start_i) state_d = StRun;
            end
            StRun: begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                if (!hz.start_i) state_d = StIdle;
                // Memory freeze outranks the load-use stall, which in turn masks the flush.
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    state_d    = StMemWait;
                    wait_d     = 8'd1;
                end else if (lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (hz.branch_taken_i) begin
                    ifid_flush = 1'b1;
                end
            end
            StMemWait: begin
                pipe_hold = !hz.dmem_ready_i;
                if (hz.dmem_ready_i) begin
                    state_d = StRun;
                    wait_d  = 8'd0;
                end else if (wait_q == 8'(MEM_TIMEOUT)) begin
                    state_d = StError;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StError: begin
                pipe_hold = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign hz.pc_write_o    = pc_write;
    assign hz.ifid_write_o  = ifid_write;
    assign hz.ifid_flush_o  = ifid_flush;
    assign hz.idex_bubble_o = idex_bubble;
    assign hz.pipe_hold_o   = pipe_hold;
    assign hz.err_o         = (state_q == StError);
    assign hz.state_o       = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == StRun || state_q == StMemWait) && !pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
`else
    assign hz.stall_cnt_o = '0;
    assign hz.flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Scoreboard bench for pipe_hazard_sequencer: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_sequencer;
    typedef struct packed {
        logic [5:0]  flags;  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, err}
        logic [2:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    localparam logic [5:0] IDL = 6'b000100;
    localparam logic [5:0] RUN = 6'b110000;
    localparam logic [5:0] STL = 6'b000100;
    localparam logic [5:0] BRO = 6'b111000;
    localparam logic [5:0] MST = 6'b000010;
    localparam logic [5:0] MRD = 6'b000000;
    localparam logic [5:0] ERR = 6'b000011;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    exp_t  exp_q[$];
    string nm_q[$];

    pipe_hazard_sequencer_if #(.CNT_W(16)) hz ();

    pipe_hazard_sequencer #(
        .MEM_TIMEOUT(4),
        .CNT_W      (16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .hz   (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] cnt(input int v);
`ifdef PERF_CNT_EN
        return 16'(v);
`else
        return (v < 0) ? 16'hffff : 16'd0;
`endif
    endfunction

    task automatic step(input string nm, input logic r, input logic s, input logic m,
                        input logic [4:0] rtx, input logic [4:0] rsd, input logic [4:0] rtd,
                        input logic b, input logic q, input logic y,
                        input logic [5:0] f, input logic [2:0] st, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        hz.start_i        = s;
        hz.idex_memread_i = m;
        hz.idex_rt_i      = rtx;
        hz.ifid_rs_i      = rsd;
        hz.ifid_rt_i      = rtd;
        hz.branch_taken_i = b;
        hz.dmem_req_i     = q;
        hz.dmem_ready_i   = y;
        e = {f, st, cnt(sc), cnt(fc)};
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin
        exp_t  e;
        exp_t  act;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = nm_q.pop_front();
                act = {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o, hz.idex_bubble_o,
                       hz.pipe_hold_o, hz.err_o, hz.state_o, hz.stall_cnt_o, hz.flush_cnt_o};
                n_checks++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL %s: got flags=%b state=%0d stall=%0d flush=%0d, expected flags=%b state=%0d stall=%0d flush=%0d",
                             nm, act.flags, act.st, act.sc, act.fc, e.flags, e.st, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b0;
        hz.start_i = 1'b0; hz.idex_memread_i = 1'b0; hz.idex_rt_i = 5'd0; hz.ifid_rs_i = 5'd0;
        hz.ifid_rt_i = 5'd0; hz.branch_taken_i = 1'b0; hz.dmem_req_i = 1'b0;
        hz.dmem_ready_i = 1'b0;
        //    name            r  s  m  rtx rsd rtd b  q  y  flags st  sc  fc
        step("reset",         0, 0, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        step("idle1",         1, 0, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        step("idle2",         1, 0, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        step("idle3",         1, 0, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        step("start_seen",    1, 1, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        step("run",           1, 1, 0, 0,  0,  0,  0, 0, 0, RUN,  1,  0,  0);
        step("loaduse_rs",    1, 1, 1, 8,  8,  0,  1, 0, 0, STL,  1,  0,  0);
        step("loaduse_rt",    1, 1, 1, 5,  3,  5,  0, 0, 0, STL,  1,  1,  0);
        step("lu_rt0",        1, 1, 1, 0,  0,  0,  0, 0, 0, RUN,  1,  2,  0);
        step("branch",        1, 1, 0, 0,  0,  0,  1, 0, 0, BRO,  1,  2,  0);
        step("post_branch",   1, 1, 0, 0,  0,  0,  0, 0, 0, RUN,  1,  2,  1);
        step("mem_req",       1, 1, 0, 0,  0,  0,  0, 1, 0, MST,  1,  2,  1);
        step("memwait1",      1, 1, 0, 0,  0,  0,  0, 1, 0, MST,  2,  3,  1);
        step("memwait_ign",   1, 1, 1, 8,  8,  0,  1, 1, 0, MST,  2,  4,  1);
        step("mem_ready",     1, 1, 0, 0,  0,  0,  0, 1, 1, MRD,  2,  5,  1);
        step("mem_done",      1, 1, 0, 0,  0,  0,  0, 0, 0, RUN,  1,  6,  1);
        step("zero_wait",     1, 1, 0, 0,  0,  0,  0, 1, 1, RUN,  1,  6,  1);
        step("stop_branch",   1, 0, 0, 0,  0,  0,  1, 0, 0, BRO,  1,  6,  1);
        step("stopped",       1, 0, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  6,  2);
        step("restart",       1, 1, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  6,  2);
        step("rerun",         1, 1, 0, 0,  0,  0,  0, 0, 0, RUN,  1,  6,  2);
        step("stop_memreq",   1, 0, 0, 0,  0,  0,  0, 1, 0, MST,  1,  6,  2);
        step("wait_t1",       1, 0, 0, 0,  0,  0,  0, 1, 0, MST,  2,  7,  2);
        step("wait_t2",       1, 0, 0, 0,  0,  0,  0, 1, 0, MST,  2,  8,  2);
        step("wait_t3",       1, 0, 0, 0,  0,  0,  0, 1, 0, MST,  2,  9,  2);
        step("wait_t4",       1, 0, 0, 0,  0,  0,  0, 1, 0, MST,  2, 10,  2);
        step("error",         1, 0, 0, 0,  0,  0,  0, 0, 0, ERR,  3, 11,  2);
        step("error_sticky",  1, 1, 0, 0,  0,  0,  0, 0, 1, ERR,  3, 11,  2);
        step("async_reset",   0, 1, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        step("idle_after",    1, 0, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        step("start2",        1, 1, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        step("run2",          1, 1, 0, 0,  0,  0,  0, 0, 0, RUN,  1,  0,  0);
        step("mem_req2",      1, 1, 0, 0,  0,  0,  0, 1, 0, MST,  1,  0,  0);
        step("memwait2",      1, 1, 0, 0,  0,  0,  0, 1, 0, MST,  2,  1,  0);
        step("reset_memwait", 0, 1, 0, 0,  0,  0,  0, 1, 0, IDL,  0,  0,  0);
        step("idle_final",    1, 0, 0, 0,  0,  0,  0, 0, 0, IDL,  0,  0,  0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
Central sequencing controller for the 5-stage pipelined CPU. It gates PC and pipeline-register updates, which are IF_ID, ID_EX, EX_MEM and MEM_WB. It inserts load-use bubbles, flushes IF_ID on taken branches, and freezes the whole pipe while a data-memory access is outstanding. It also owns start-up sequencing from start_i and a sticky memory-timeout error.

Parameters:
MEM_TIMEOUT, 15, max MEM_WAIT cycles before fatal error (1..255)
CNT_W, 16, width of performance counters

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  level run enable (same signal as PC start_i)
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  5  rt of instruction in EX
ifid_rs_i  in  5  rs of instruction in ID
ifid_rt_i  in  5  rt of instruction in ID
branch_taken_i  in  1  branch in ID resolved taken this cycle
dmem_req_i  in  1  EX/MEM stage issuing data-memory access
dmem_ready_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF_ID load enable
ifid_flush_o  out  1  IF_ID clears to NOP on next edge
idex_bubble_o  out  1  ID_EX loads zeroed control (bubble)
pipe_hold_o  out  1  ID_EX, EX_MEM and MEM_WB hold contents
err_o  out  1  sticky memory-timeout error
state_o  out  3  current FSM state encoding
stall_cnt_o  out  CNT_W  saturating stall-cycle count
flush_cnt_o  out  CNT_W  saturating flush count

Behaviour:
- States and encodings: IDLE=0, RUN=1, MEM_WAIT=2, ERROR=3.
- Reset (rst_i=0, async): state=IDLE, wait counter=0, err_o=0, counters=0.
- Outputs are combinational from state plus inputs (Mealy). Hazard outputs therefore act in the same cycle the hazard is presented.
- Load-use hazard definition: lu = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
- IDLE outputs: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pipe_hold_o=0.
  - start_i=1 sampled -> RUN.
- RUN default outputs: pc_write_o=1, ifid_write_o=1, all others 0.
- RUN priority, highest first:
  - dmem_req_i & !dmem_ready_i -> pc_write_o=0, ifid_write_o=0, pipe_hold_o=1; next state MEM_WAIT with wait counter=1.
  - lu -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. Any simultaneous branch_taken_i flush is suppressed; the branch re-resolves after the stall. Stays in RUN; exactly one bubble per load.
  - branch_taken_i -> ifid_flush_o=1, pc_write_o=1.
- RUN with start_i=0: the current cycle completes normally, then -> IDLE. A pending MEM_WAIT entry takes priority over this.
- MEM_WAIT outputs: pc_write_o=0, ifid_write_o=0, pipe_hold_o = !dmem_ready_i. branch_taken_i and lu are ignored.
  - dmem_ready_i=1 -> RUN; the pipe advances in this same cycle.
  - Otherwise the wait counter increments. If dmem_ready_i=0 while the counter equals MEM_TIMEOUT -> ERROR.
  - start_i is ignored in MEM_WAIT.
- ERROR: err_o=1, pc_write_o=0, ifid_write_o=0, pipe_hold_o=1. Leaves only on reset.
- Reset mid-MEM_WAIT: immediate IDLE; the outstanding access is abandoned.
- dmem_req_i with dmem_ready_i=1 in the same RUN cycle: no stall (zero-wait memory).

Optional Feature:
PERF_CNT_EN
- Defined: stall_cnt_o increments each cycle that state is RUN or MEM_WAIT with pc_write_o=0. flush_cnt_o increments each cycle ifid_flush_o=1. Both saturate at all-ones and clear only on reset.
- Undefined: no counter registers; stall_cnt_o and flush_cnt_o tie to 0.

Test Plan:
- Start-up: reset, start_i=0 for 3 cycles -> state_o=0, idex_bubble_o=1, pc_write_o=0. Raise start_i -> state_o=1 next cycle with pc_write_o=1.
- Load-use: RUN with idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8, branch_taken_i=1 -> same cycle pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. Repeat with idex_rt_i=0 -> no stall.
- Branch: branch_taken_i=1, no lu -> ifid_flush_o=1 for 1 cycle. flush_cnt_o=1 when PERF_CNT_EN is defined.
- Memory wait: dmem_req_i=1, dmem_ready_i low for 3 cycles then high -> pipe_hold_o=1 for 3 cycles, 0 in the ready cycle, then RUN. stall_cnt_o=4.
- Timeout: MEM_TIMEOUT=4, dmem_ready_i held 0 -> ERROR (state_o=3, err_o=1) after wait counter hits 4. err_o stays set until rst_i=0, which returns state_o=0 asynchronously.
